// File: rtl/hsid_min_max_sel.sv
// Running minimum / maximum selector over the final accumulated distances of a
// library scan; reports the best and worst matching library entry with a done pulse.
module hsid_min_max_sel #(
    parameter int DATA_WIDTH_ACC    = 32,
    parameter int HSP_LIBRARY_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [HSP_LIBRARY_WIDTH-1:0] library_size,
    input  logic                         acc_valid,
    input  logic [DATA_WIDTH_ACC-1:0]    acc_value,
    input  logic                         acc_last,
    input  logic [HSP_LIBRARY_WIDTH-1:0] acc_ref,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_WIDTH_ACC-1:0]    min_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
    output logic [DATA_WIDTH_ACC-1:0]    max_value,
    output logic [HSP_LIBRARY_WIDTH-1:0] max_ref,
    output logic [HSP_LIBRARY_WIDTH-1:0] entry_count,
    output logic                         error
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [HSP_LIBRARY_WIDTH-1:0] COUNT_ONE = 1;

    state_t                         state;
    logic [HSP_LIBRARY_WIDTH-1:0]   library_size_q;
    logic                           final_beat;
    logic [HSP_LIBRARY_WIDTH-1:0]   count_next;

    assign final_beat = acc_valid & acc_last;
    assign count_next = entry_count + COUNT_ONE;

    // Min starts at all ones and max at zero so the first entry loads both
    // through the ordinary strict comparisons; ties keep the earlier reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            library_size_q <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            min_value      <= '1;
            min_ref        <= '0;
            max_value      <= '0;
            max_ref        <= '0;
            entry_count    <= '0;
            error          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        library_size_q <= library_size;
                        entry_count    <= '0;
                        error          <= 1'b0;
                        min_value      <= '1;
                        min_ref        <= '0;
                        max_value      <= '0;
                        max_ref        <= '0;
                        if (library_size == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (final_beat) begin
                            error <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (final_beat) begin
                        entry_count <= count_next;
                        if (acc_value < min_value) begin
                            min_value <= acc_value;
                            min_ref   <= acc_ref;
                        end
                        if (acc_value > max_value) begin
                            max_value <= acc_value;
                            max_ref   <= acc_ref;
                        end
                        // Leaving RUN here means a surplus final beat lands in
                        // IDLE/DONE and is flagged instead of wrapping the count.
                        if (count_next == library_size_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hsid_min_max_sel.md
Name: hsid_min_max_sel

Overview:
Consumer at the far end of the squared-difference accumulator output stream (acc_valid/acc_value/acc_last/acc_ref). It takes one final accumulated distance per library entry, marked by acc_last, and keeps the running minimum and maximum with their library references. When the programmed number of library entries has been seen, it reports a done pulse with the best and worst match. It sits between the accumulator array and the HSID result registers / CSR interface.

Parameters:
DATA_WIDTH_ACC, HSID_DATA_WIDTH_ACC (hsid_pkg), width of the accumulated distance.
HSP_LIBRARY_WIDTH, HSID_HSP_LIBRARY_WIDTH (hsid_pkg), width of the library reference index and entry count.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a new selection; sampled only in IDLE or DONE.
library_size  in  HSP_LIBRARY_WIDTH  number of library entries expected; latched on accepted start.
acc_valid  in  1  accumulator output beat valid.
acc_value  in  DATA_WIDTH_ACC  accumulated squared difference.
acc_last  in  1  beat carries the final accumulation for one library entry.
acc_ref  in  HSP_LIBRARY_WIDTH  library reference of the beat.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse when the result is complete.
min_value  out  DATA_WIDTH_ACC  smallest final distance seen.
min_ref  out  HSP_LIBRARY_WIDTH  reference of min_value.
max_value  out  DATA_WIDTH_ACC  largest final distance seen.
max_ref  out  HSP_LIBRARY_WIDTH  reference of max_value.
entry_count  out  HSP_LIBRARY_WIDTH  final beats consumed in the current run.
error  out  1  sticky protocol error flag.

Behaviour:
- Reset values: busy=0, done=0, min_value=all ones, min_ref=0, max_value=0, max_ref=0, entry_count=0, error=0; FSM=IDLE.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE/DONE, start=1:
  - Latch library_size; clear entry_count and error.
  - Set min_value=all ones, max_value=0, both refs=0.
  - If library_size==0, go to DONE (done pulses next cycle, outputs keep their reset-like values). Otherwise go to RUN.
- RUN, start ignored.
- RUN, final beat (acc_valid=1 and acc_last=1):
  - entry_count increments.
  - If acc_value < min_value (strict), load min_value and min_ref=acc_ref.
  - If acc_value > max_value (strict), load max_value and max_ref=acc_ref.
  - Ties keep the earlier reference.
  - For the first entry both registers load, because min starts at all ones and max at 0. The exception is an acc_value of exactly all ones, which loads only max; min_ref then stays 0 and the value is correct.
- Beats with acc_valid=1 and acc_last=0 are ignored. acc_valid=0 means no action.
- When the final beat makes entry_count == latched library_size: go to DONE on that edge. done=1 and busy=0 in the following cycle, with all result outputs already updated, so latency is one cycle from the last beat to done.
- DONE lasts exactly one cycle (done=1), then returns to IDLE. Results hold until the next accepted start. A start in the DONE cycle is accepted (back-to-back runs).
- Error:
  - A final beat in IDLE or DONE sets error=1 and is otherwise ignored. Results are not changed.
  - error is cleared only by an accepted start or by rst.
- entry_count never wraps. A further final beat with entry_count == library_size cannot occur in RUN, because the FSM has already left RUN.
- Reset mid-run: next cycle all outputs hold reset values and the FSM is in IDLE. The partial result is discarded.
- Comparisons are unsigned over the full DATA_WIDTH_ACC.

Test Plan:
- Basic: start, library_size=4; final beats (value,ref) = (50,0),(20,1),(90,2),(35,3), one per cycle → min=20/ref1, max=90/ref2, entry_count=4, done pulse exactly one cycle after the (35,3) beat, busy low with done.
- Gaps and non-last beats: library_size=3; between final beats, inject acc_valid=1, acc_last=0 with value 1, plus idle cycles. Final beats (10,0),(10,1),(7,2) → non-last values ignored; tie keeps min_ref=0 until 7 arrives (min=7/ref2); max=10/ref0 (tie keeps ref0).
- Zero size: start with library_size=0 → done the next cycle, min_value=all ones, max_value=0, entry_count=0, no busy.
- Protocol error: in IDLE, drive a final beat (5,3) → error=1, min/max unchanged. Then start with library_size=1 and beat (8,1) → error cleared at start, result min=max=8/ref1.
- Reset mid-run: library_size=4, two final beats sent, then rst for one cycle → all outputs at reset values, IDLE. A new run with size 1 and beat (3,0) completes normally.
- Back-to-back: assert start in the DONE cycle with library_size=2, beats (100,5),(0,6) → second run min=0/ref6, max=100/ref5; no gap cycle is needed.
